i2s_tx: RTL

- Stand-alone I2S serializer that takes the place of the inline bit-counter/shift logic in the video/audio top level.
- Sits downstream of the audio volume/mix stage. Consumes signed 16-bit L/R sample pairs through a valid/ready handshake and drives hp_bck/hp_ws/hp_din toward the amplifier.
- Uses Philips I2S format (WS one BCK ahead of MSB) with 32-bit frames and a one-deep holding buffer, and reports underruns.

---
 rtl/i2s_pkg.sv | 13 +
 rtl/i2s_bck_gen.sv | 34 +++
 rtl/i2s_tx.sv | 108 ++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S transmitter.
package i2s_pkg;
  localparam int FRAME_BITS    = 32;
  localparam int SLOT_BITS     = 16;
  localparam int LOAD_SLOT     = 1;
  localparam int WS_RIGHT_SLOT = 16;
  localparam int SLOT_CNT_W    = $clog2(FRAME_BITS);

  typedef struct packed {
    logic signed [15:0] l;
    logic signed [15:0] r;
  } sample_pair_t;
endpackage

// File: rtl/i2s_bck_gen.sv
// Bit-clock divider: toggles BCK every max(div,1)+1 clk and flags the falling edge.
module i2s_bck_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div_i,
  output logic             bck_o,
  output logic             fall_tick_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d, lim;
  logic             bck_q, bck_d, tick;

  // >= rather than == so a shrinking div never lets cnt run the full wrap.
  always_comb begin
    lim   = (div_i == '0) ? DIV_W'(1) : div_i;
    tick  = (cnt_q >= lim);
    cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
    bck_d = tick ? ~bck_q : bck_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      bck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      bck_q <= bck_d;
    end
  end

  assign bck_o       = bck_q;
  assign fall_tick_o = tick & bck_q;
endmodule

// File: rtl/i2s_tx.sv
// Philips I2S serializer: 32-bit frames, one-deep holding buffer, underrun repeat.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int DIV_W  = 8,
  parameter int STEREO = 1
) (
  input  logic               clk,
  input  logic               pll_lock,
  input  logic [DIV_W-1:0]   div,
  input  logic               mute,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_l,
  input  logic signed [15:0] in_r,
  output logic               hp_bck,
  output logic               hp_ws,
  output logic               hp_din,
  output logic               frame_strobe,
  output logic               underrun
);
  logic                  fall_tick, load, accept;
  logic [SLOT_CNT_W-1:0] slot_q, slot_d;
  logic                  ws_q, ws_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  full_q, full_d;
  logic                  strobe_q, strobe_d, under_q, under_d;
  logic signed [15:0]    avg;
  sample_pair_t          buf_q, buf_d, last_q, last_d, load_pair;

  function automatic logic signed [15:0] mono_avg(input logic signed [15:0] a,
                                                  input logic signed [15:0] b);
    logic signed [16:0] sum;
    sum = {a[15], a} + {b[15], b};
    return sum[16:1];
  endfunction

  i2s_bck_gen #(.DIV_W(DIV_W)) u_bck (
    .clk         (clk),
    .rst_n       (pll_lock),
    .div_i       (div),
    .bck_o       (hp_bck),
    .fall_tick_o (fall_tick)
  );

  always_comb begin
    load      = fall_tick && (slot_q == SLOT_CNT_W'(LOAD_SLOT - 1));
    accept    = in_valid && !full_q;
    load_pair = full_q ? buf_q : last_q;
    avg       = mono_avg(in_l, in_r);
    slot_d    = slot_q;
    ws_d      = ws_q;
    shift_d   = shift_q;
    full_d    = full_q;
    buf_d     = buf_q;
    last_d    = last_q;
    strobe_d  = 1'b0;
    under_d   = 1'b0;
    if (fall_tick) begin
      slot_d  = slot_q + SLOT_CNT_W'(1);
      ws_d    = (slot_d >= SLOT_CNT_W'(WS_RIGHT_SLOT));
      shift_d = load ? (mute ? '0 : load_pair) : {shift_q[FRAME_BITS-2:0], 1'b0};
    end
    // Last-pair keeps the unmuted pair so a later repeat plays real audio.
    if (load) begin
      strobe_d = 1'b1;
      under_d  = !full_q;
      last_d   = load_pair;
      full_d   = 1'b0;
    end
    if (accept) begin
      full_d  = 1'b1;
      buf_d.l = (STEREO != 0) ? in_l : avg;
      buf_d.r = (STEREO != 0) ? in_r : avg;
    end
  end

  always_ff @(posedge clk or negedge pll_lock) begin
    if (!pll_lock) begin
      slot_q   <= '0;
      ws_q     <= 1'b0;
      shift_q  <= '0;
      full_q   <= 1'b0;
      last_q   <= '0;
      strobe_q <= 1'b0;
      under_q  <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      ws_q     <= ws_d;
      shift_q  <= shift_d;
      full_q   <= full_d;
      last_q   <= last_d;
      strobe_q <= strobe_d;
      under_q  <= under_d;
    end
  end

  // Buffer contents are qualified by full_q, so they need no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign in_ready     = !full_q;
  assign hp_ws        = ws_q;
  assign hp_din       = shift_q[FRAME_BITS-1];
  assign frame_strobe = strobe_q;
  assign underrun     = under_q;
endmodule
